// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master round-robin data-memory arbiter and access sequencer
// Optional DMEM_ARB_FIXED_PRIO_EN: master 0 always wins a tie and no last-winner register exists.
module dmem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [2:0]    m0_funct3,
    output logic          m0_gnt,
    output logic          m0_done,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [2:0]    m1_funct3,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [DW-1:0] rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic [2:0]    mem_funct3,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [2:0]    lat_funct3;
    logic [DW-1:0] rdata_q;
    logic          grant_any;
    logic          grant_sel;

    assign grant_any = m0_req | m1_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign grant_sel = !m0_req;
`else
    logic last;

    // On a tie the master that did not win last time is selected
    assign grant_sel = m1_req && (!m0_req || !last);

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (state == IDLE && grant_any) begin
            last <= grant_sel;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= 3'b000;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_any) begin
                owner      <= grant_sel;
                lat_we     <= grant_sel ? m1_we     : m0_we;
                lat_addr   <= grant_sel ? m1_addr   : m0_addr;
                lat_wdata  <= grant_sel ? m1_wdata  : m0_wdata;
                lat_funct3 <= grant_sel ? m1_funct3 : m0_funct3;
            end
            if (state == ACCESS && !lat_we) begin
                rdata_q <= mem_rd;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_done   = 1'b0;
        m1_done   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = ACCESS;
                    m0_gnt    = !grant_sel;
                    m1_gnt    = grant_sel;
                end
            end
            ACCESS: begin
                state_nxt = DONE;
                mem_read  = !lat_we;
                mem_write = lat_we;
            end
            DONE: begin
                state_nxt = IDLE;
                m0_done   = !owner;
                m1_done   = owner;
            end
            default: state_nxt = IDLE;
        endcase
        // Nothing may strobe or commit while reset is high, even mid-access
        if (reset) begin
            m0_gnt    = 1'b0;
            m1_gnt    = 1'b0;
            m0_done   = 1'b0;
            m1_done   = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    assign mem_a      = lat_addr;
    assign mem_wd     = lat_wdata;
    assign mem_funct3 = lat_funct3;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a transaction-level arbitration model
module tb_dmem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic [2:0]    m0_funct3 = 3'b000;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic [2:0]    m1_funct3 = 3'b000;
    logic          m0_gnt, m0_done, m1_gnt, m1_done;
    logic [DW-1:0] rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [2:0]    mem_funct3;
    logic [DW-1:0] mem_rd;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_funct3(m0_funct3), .m0_gnt(m0_gnt), .m0_done(m0_done),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_funct3(m1_funct3), .m1_gnt(m1_gnt), .m1_done(m1_done),
        .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_funct3(mem_funct3), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            m;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [2:0]    f3;
        logic [DW-1:0] rd;
        int            g;
        bit            abort;
    } txn_t;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ld_fmt(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [2:0] f3);
        case (f3)
            3'b000:  return {old[31:8], wd[7:0]};
            3'b001:  return {old[31:16], wd[15:0]};
            default: return wd;
        endcase
    endfunction

    // Behavioural data memory: combinational read, write on the clock edge
    logic [31:0] pmem [0:511] = '{default: 32'h0};
    assign mem_rd = ld_fmt(pmem[mem_a], mem_funct3);
    always @(posedge clk) if (mem_write) pmem[mem_a] <= st_merge(pmem[mem_a], mem_wd, mem_funct3);

    txn_t exp_q[$];
    txn_t inflight[$];
    txn_t drv0[$], drv1[$];
    txn_t sc0[$], sc1[$];
    int   start0 = 0, start1 = 0;
    bit   gs0 = 0, gs1 = 0;
    bit   rst_req = 1'b1;
    bit   rst_pending = 1'b0;

    logic [31:0] ref_mem [0:511];
    int          ref_last = 1;
    logic [31:0] ref_rdata = 32'h0;

    // Monitor: compares every cycle against the expectations the stimulus side queued
    txn_t mtx;
    bit   acc;
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_quiet", {m0_gnt, m1_gnt, m0_done, m1_done, mem_read, mem_write}, 64'h0);
            rst_pending = 1'b1;
        end else begin
            if (rst_pending) begin
                chk("rdata_after_reset", rdata, 64'h0);
                rst_pending = 1'b0;
            end
            if (m0_gnt) gs0 = 1'b1;
            if (m1_gnt) gs1 = 1'b1;
            while (exp_q.size() > 0 && exp_q[0].g < cyc) begin
                chk("gnt_missing", 64'h0, 64'h1);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].g == cyc) begin
                mtx = exp_q.pop_front();
                chk("gnt_owner", {m1_gnt, m0_gnt}, (mtx.m == 1) ? 64'h2 : 64'h1);
                inflight.push_back(mtx);
            end else begin
                chk("no_gnt", {m1_gnt, m0_gnt}, 64'h0);
            end
            acc = 1'b0;
            foreach (inflight[k]) begin
                if (inflight[k].g + 1 == cyc && !inflight[k].abort) begin
                    acc = 1'b1;
                    mtx = inflight[k];
                end
            end
            if (acc) begin
                chk("strobes", {mem_read, mem_write}, {62'h0, !mtx.we, mtx.we});
                chk("mem_a", mem_a, mtx.addr);
                chk("mem_funct3", mem_funct3, mtx.f3);
                if (mtx.we) chk("mem_wd", mem_wd, mtx.wd);
            end else begin
                chk("strobes_idle", {mem_read, mem_write}, 64'h0);
            end
            if (inflight.size() > 0 && inflight[0].g + 2 == cyc) begin
                mtx = inflight.pop_front();
                if (mtx.abort) begin
                    chk("done_after_abort", {m1_done, m0_done}, 64'h0);
                end else begin
                    chk("done_owner", {m1_done, m0_done}, (mtx.m == 1) ? 64'h2 : 64'h1);
                    chk("rdata", rdata, mtx.rd);
                end
            end else begin
                chk("no_done", {m1_done, m0_done}, 64'h0);
            end
            while (inflight.size() > 0 && inflight[0].g + 2 < cyc) void'(inflight.pop_front());
        end
    end

    // One clock of stimulus: masters keep presenting queued work until granted
    task automatic step();
        @(posedge clk);
        #1;
        reset = rst_req;
        if (gs0) begin
            if (drv0.size() > 0) void'(drv0.pop_front());
            gs0 = 1'b0;
        end
        if (gs1) begin
            if (drv1.size() > 0) void'(drv1.pop_front());
            gs1 = 1'b0;
        end
        if (drv0.size() > 0 && cyc >= start0) begin
            m0_req = 1'b1; m0_we = drv0[0].we; m0_addr = drv0[0].addr;
            m0_wdata = drv0[0].wd; m0_funct3 = drv0[0].f3;
        end else begin
            m0_req = 1'b0; m0_we = 1'($urandom); m0_addr = AW'($urandom);
            m0_wdata = $urandom; m0_funct3 = 3'($urandom);
        end
        if (drv1.size() > 0 && cyc >= start1) begin
            m1_req = 1'b1; m1_we = drv1[0].we; m1_addr = drv1[0].addr;
            m1_wdata = drv1[0].wd; m1_funct3 = drv1[0].f3;
        end else begin
            m1_req = 1'b0; m1_we = 1'($urandom); m1_addr = AW'($urandom);
            m1_wdata = $urandom; m1_funct3 = 3'($urandom);
        end
    endtask

    function automatic txn_t mk(input bit we, input int addr, input logic [31:0] wd,
                                input logic [2:0] f3);
        txn_t t;
        t.m = 0; t.we = we; t.addr = AW'(addr); t.wd = wd; t.f3 = f3;
        t.rd = 32'h0; t.g = 0; t.abort = 1'b0;
        return t;
    endfunction

    // Predict the grant schedule: the arbiter frees up every 3 cycles and serves pending masters
    task automatic run_scn(input int o0, input int o1, input bit rst_access);
        int   s, f, t, e0, e1, i0, i1, pick, budget;
        int   av[2];
        txn_t tx;
        s = cyc + 1; f = s; i0 = 0; i1 = 0;
        av[0] = s + o0; av[1] = s + o1;
        start0 = s + o0; start1 = s + o1;
        foreach (sc0[k]) drv0.push_back(sc0[k]);
        foreach (sc1[k]) drv1.push_back(sc1[k]);
        while (i0 < sc0.size() || i1 < sc1.size()) begin
            e0 = (i0 < sc0.size()) ? ((av[0] > f) ? av[0] : f) : 32'h7fffffff;
            e1 = (i1 < sc1.size()) ? ((av[1] > f) ? av[1] : f) : 32'h7fffffff;
            t  = (e0 < e1) ? e0 : e1;
            if (e0 == t && e1 == t) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                pick = 0;
`else
                pick = (ref_last == 1) ? 0 : 1;
`endif
            end else begin
                pick = (e0 == t) ? 0 : 1;
            end
            if (pick == 1) begin tx = sc1[i1]; i1++; end
            else begin tx = sc0[i0]; i0++; end
            tx.m = pick; tx.g = t; tx.abort = rst_access;
            if (!rst_access) begin
                if (tx.we) ref_mem[tx.addr] = st_merge(ref_mem[tx.addr], tx.wd, tx.f3);
                else ref_rdata = ld_fmt(ref_mem[tx.addr], tx.f3);
            end
            tx.rd = ref_rdata;
            exp_q.push_back(tx);
            ref_last = pick; f = t + 3; av[pick] = t + 1;
        end
        sc0.delete(); sc1.delete();
        if (rst_access) begin
            ref_last = 1; ref_rdata = 32'h0;
            step();
            rst_req = 1'b1;
            step();
            rst_req = 1'b0;
        end
        budget = 0;
        while ((exp_q.size() > 0 || inflight.size() > 0 || drv0.size() > 0 || drv1.size() > 0)
               && budget < 300) begin
            step();
            budget++;
        end
        if (budget >= 300) chk("scenario_timeout", 64'h1, 64'h0);
        step();
    endtask

    logic [2:0] ld_codes [5];
    initial begin
        int n0, n1;
        ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
        repeat (3) step();
        rst_req = 1'b0;
        step();

        // Tie from reset: both masters hold two requests each
        sc0 = '{mk(1, 1, 32'h11111111, 3'b010), mk(0, 1, 0, 3'b010)};
        sc1 = '{mk(1, 2, 32'h22222222, 3'b010), mk(0, 2, 0, 3'b010)};
        run_scn(0, 0, 0);

        sc0 = '{mk(1, 5, 32'hDEADBEEF, 3'b010)};
        run_scn(0, 0, 0);
        sc0 = '{mk(0, 5, 0, 3'b010)};
        run_scn(0, 0, 0);

        sc0 = '{mk(1, 7, 32'h000000F0, 3'b010)};
        run_scn(0, 0, 0);
        sc1 = '{mk(0, 7, 0, 3'b000)};
        run_scn(0, 0, 0);

        sc0 = '{mk(1, 3, 32'h12345678, 3'b010)};
        run_scn(0, 0, 0);
        sc1 = '{mk(1, 3, 32'h00000001, 3'b010)};
        run_scn(0, 0, 1);
        sc0 = '{mk(0, 3, 0, 3'b010)};
        run_scn(0, 0, 0);

        sc0 = '{mk(1, 9, 32'hCAFEF00D, 3'b010)};
        sc1 = '{mk(0, 9, 0, 3'b010)};
        run_scn(0, 1, 0);
        sc0 = '{mk(0, 9, 0, 3'b001)};
        sc1 = '{mk(1, 10, 32'h0BADC0DE, 3'b010)};
        run_scn(0, 0, 0);

        sc0 = '{mk(1, 11, 32'hA5A5A5A5, 3'b010)};
        run_scn(0, 0, 0);
        sc0 = '{mk(0, 11, 0, 3'b010), mk(1, 12, 32'h0, 3'b010)};
        run_scn(0, 0, 0);

        for (int s = 0; s < 40; s++) begin
            n0 = $urandom_range(0, 3);
            n1 = (n0 == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
            for (int i = 0; i < n0; i++) begin
                if ($urandom_range(0, 1) == 1)
                    sc0.push_back(mk(1, $urandom_range(0, 15), $urandom, 3'($urandom_range(0, 2))));
                else
                    sc0.push_back(mk(0, $urandom_range(0, 15), 0, ld_codes[$urandom_range(0, 4)]));
            end
            for (int i = 0; i < n1; i++) begin
                if ($urandom_range(0, 1) == 1)
                    sc1.push_back(mk(1, $urandom_range(0, 15), $urandom, 3'($urandom_range(0, 2))));
                else
                    sc1.push_back(mk(0, $urandom_range(0, 15), 0, ld_codes[$urandom_range(0, 4)]));
            end
            run_scn($urandom_range(0, 3), $urandom_range(0, 3), 0);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
